// File: rtl/xdbg_monitor_pkg.sv
// Shared types for the debug monitor: trap cause codes, FSM states and header size.
package xdbg_monitor_pkg;

   typedef enum logic [1:0] {
      CauseNone = 2'b00,
      CauseTrap = 2'b01,
      CauseTmo  = 2'b10,
      CauseReq  = 2'b11
   } cause_e;

   typedef enum logic [2:0] {
      StRun,
      StSettle,
      StFetch,
      StWait,
      StSend,
      StDone
   } state_e;

   // Words 0..2 (count, cause/access, pc) come from latched state, not the register file.
   localparam int unsigned HdrWords = 3;

endpackage

// File: rtl/xdbg_monitor_if.sv
// Valid/ready snapshot stream carried out of the debug monitor.
interface xdbg_monitor_if #(
   parameter int unsigned DATA_W = 32
);
   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] data;
   logic              last;

   modport master (output valid, output data, output last, input ready);
   modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/xdbg_cycle_cnt.sv
// Saturating cycle counter; with XDBG_TIMEOUT_EN defined it also flags count == TIMEOUT-1.
module xdbg_cycle_cnt #(
   parameter int unsigned W       = 32,
   parameter int unsigned TIMEOUT = 1000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         tmo
);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (en && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

`ifdef XDBG_TIMEOUT_EN
   assign tmo = (count == W'(TIMEOUT - 1));
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT;
   assign tmo            = 1'b0;
`endif

endmodule

// File: rtl/xdbg_monitor.sv
// picoVersat debug monitor: halts the core on trap/timeout/request and streams a snapshot.
// Watchdog timeout is only present when XDBG_TIMEOUT_EN is defined.
module xdbg_monitor
   import xdbg_monitor_pkg::*;
#(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned ADDR_W      = 12,
   parameter int unsigned NREGS       = 16,
   parameter int unsigned REGF_ADDR_W = 4,
   parameter int unsigned TIMEOUT     = 1000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   trap,
   input  logic                   dump_req,
   input  logic                   data_we,
   input  logic [ADDR_W-1:0]      data_addr,
   input  logic [ADDR_W-1:0]      pc,
   output logic                   halt,
   output logic [REGF_ADDR_W-1:0] regf_raddr,
   input  logic [DATA_W-1:0]      regf_rdata,
   xdbg_monitor_if.master         out,
   output logic                   done
);

   localparam int unsigned LastIdx = NREGS + 2;
   localparam int unsigned IDX_W   = $clog2(NREGS + 3);

   state_e              state;
   logic [IDX_W-1:0]    idx;
   cause_e              cause_lat;
   logic                we_lat;
   logic [ADDR_W-1:0]   addr_lat;
   logic [ADDR_W-1:0]   pc_lat;
   logic [DATA_W-1:0]   cnt_lat;
   logic [DATA_W-1:0]   count;
   logic                tmo;
   logic                event_hit;
   cause_e              ev_cause;
   logic [DATA_W-1:0]   hdr_word;
   logic                out_valid_q;
   logic                out_last_q;
   logic [DATA_W-1:0]   out_data_q;

   xdbg_cycle_cnt #(
      .W       (DATA_W),
      .TIMEOUT (TIMEOUT)
   ) u_cycle_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (state == StRun),
      .count (count),
      .tmo   (tmo)
   );

   assign event_hit = trap | tmo | dump_req;
   assign ev_cause  = trap ? CauseTrap : (tmo ? CauseTmo : CauseReq);

   always_comb begin
      hdr_word = '0;
      case (idx)
         IDX_W'(0): hdr_word = cnt_lat;
         IDX_W'(1): begin
            hdr_word[ADDR_W-1:0]     = addr_lat;
            hdr_word[DATA_W-3]       = we_lat;
            hdr_word[DATA_W-1 -: 2]  = cause_lat;
         end
         default:   hdr_word[ADDR_W-1:0] = pc_lat;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= StRun;
         halt        <= 1'b0;
         done        <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
         regf_raddr  <= '0;
         idx         <= '0;
         cause_lat   <= CauseNone;
         we_lat      <= 1'b0;
         addr_lat    <= '0;
         pc_lat      <= '0;
         cnt_lat     <= '0;
      end else begin
         case (state)
            StRun: begin
               if (event_hit) begin
                  cause_lat <= ev_cause;
                  we_lat    <= data_we;
                  addr_lat  <= data_addr;
                  pc_lat    <= pc;
                  cnt_lat   <= count;
                  halt      <= 1'b1;
                  state     <= StSettle;
               end
            end
            // Lets the core's final in-flight write reach the register file.
            StSettle: state <= StFetch;
            StFetch: begin
               if (idx < IDX_W'(HdrWords)) begin
                  out_data_q  <= hdr_word;
                  out_valid_q <= 1'b1;
                  out_last_q  <= (idx == IDX_W'(LastIdx));
                  state       <= StSend;
               end else begin
                  state <= StWait;
               end
            end
            StWait: begin
               out_data_q  <= regf_rdata;
               out_valid_q <= 1'b1;
               out_last_q  <= (idx == IDX_W'(LastIdx));
               state       <= StSend;
            end
            StSend: begin
               if (out.ready) begin
                  out_valid_q <= 1'b0;
                  out_last_q  <= 1'b0;
                  if (out_last_q) begin
                     done  <= 1'b1;
                     state <= StDone;
                  end else begin
                     idx   <= idx + 1'b1;
                     // Read address runs one word ahead so it is stable through FETCH/WAIT.
                     if (idx >= IDX_W'(2)) begin
                        regf_raddr <= REGF_ADDR_W'(idx - IDX_W'(2));
                     end
                     state <= StFetch;
                  end
               end
            end
            StDone:  state <= StDone;
            default: state <= StRun;
         endcase
      end
   end

   assign out.valid = out_valid_q;
   assign out.last  = out_last_q;
   assign out.data  = out_data_q;

endmodule

// File: tb/tb_xdbg_monitor.sv
// Directed self-checking bench for xdbg_monitor (16-register instance plus a 1-register one).
module tb_xdbg_monitor;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        trap, dump_req, data_we, halt, done;
   logic [11:0] data_addr, pc;
   logic [3:0]  raddr;
   logic [31:0] rdata;
   logic        trap1, dump_req1, data_we1, halt1, done1;
   logic [11:0] data_addr1, pc1;
   logic [3:0]  raddr1;
   logic [31:0] rdata1;

   always #5 clk = ~clk;

   xdbg_monitor_if #(.DATA_W(32)) m ();
   xdbg_monitor_if #(.DATA_W(32)) m1 ();

   xdbg_monitor #(
      .DATA_W(32), .ADDR_W(12), .NREGS(16), .REGF_ADDR_W(4), .TIMEOUT(100)
   ) dut (
      .clk(clk), .rst(rst), .trap(trap), .dump_req(dump_req), .data_we(data_we),
      .data_addr(data_addr), .pc(pc), .halt(halt), .regf_raddr(raddr),
      .regf_rdata(rdata), .out(m), .done(done)
   );

   xdbg_monitor #(
      .DATA_W(32), .ADDR_W(12), .NREGS(1), .REGF_ADDR_W(4), .TIMEOUT(1000)
   ) dut1 (
      .clk(clk), .rst(rst), .trap(trap1), .dump_req(dump_req1), .data_we(data_we1),
      .data_addr(data_addr1), .pc(pc1), .halt(halt1), .regf_raddr(raddr1),
      .regf_rdata(rdata1), .out(m1), .done(done1)
   );

   logic [31:0] regf_mem [16];
   initial for (int i = 0; i < 16; i++) regf_mem[i] = 32'h5A00_0000 + 32'(i) * 32'h0001_0203;

   // Synchronous-read register file: data valid the cycle after the address.
   always @(posedge clk) begin
      rdata  <= regf_mem[raddr];
      rdata1 <= regf_mem[raddr1];
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   logic [31:0] q0[$], q1[$];
   bit          l0[$], l1[$];
   bit          stall0 = 1'b0;
   logic [31:0] stall_data0;

   always @(negedge clk) begin
      if (stall0) begin
         check("stall_valid", 32'(m.valid), 32'd1);
         check("stall_data", m.data, stall_data0);
      end
      stall0 = 1'b0;
      if (m.valid && m.ready) begin
         q0.push_back(m.data);
         l0.push_back(m.last);
      end else if (m.valid) begin
         stall0      = 1'b1;
         stall_data0 = m.data;
      end
      if (m1.valid && m1.ready) begin
         q1.push_back(m1.data);
         l1.push_back(m1.last);
      end
   end

   function automatic logic [31:0] exp_word(input int k, input logic [31:0] cnt,
                                            input logic [1:0] cause, input logic we,
                                            input logic [11:0] addr, input logic [11:0] pcv);
      if (k == 0) return cnt;
      if (k == 1) return {cause, we, 17'b0, addr};
      if (k == 2) return {20'b0, pcv};
      return regf_mem[k-3];
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      {trap, dump_req, data_we, trap1, dump_req1, data_we1} = '0;
      {data_addr, pc, data_addr1, pc1} = '0;
      m.ready  = 1'b1;
      m1.ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      q0.delete(); l0.delete(); q1.delete(); l1.delete();
   endtask

   // Raise the event during RUN cycle at_cycle (count == at_cycle at the event edge).
   task automatic fire(input int at_cycle, input bit t, input bit r, input bit we,
                       input logic [11:0] a, input logic [11:0] p, input int sel);
      repeat (at_cycle) begin
         @(posedge clk);
         #1;
      end
      if (sel == 0) begin
         trap = t; dump_req = r; data_we = we; data_addr = a; pc = p;
      end else begin
         trap1 = t; dump_req1 = r; data_we1 = we; data_addr1 = a; pc1 = p;
      end
      check("pre_halt", 32'(sel == 0 ? halt : halt1), 32'd0);
      @(posedge clk);
      #1;
      {trap, dump_req, trap1, dump_req1} = '0;
      check("halt", 32'(sel == 0 ? halt : halt1), 32'd1);
   endtask

   task automatic run_dump(input int sel, input bit toggle, output int cyc, output int first_v);
      cyc     = 0;
      first_v = -1;
      while (cyc < 400) begin
         @(posedge clk);
         #1;
         cyc++;
         if (first_v < 0 && (sel == 0 ? m.valid : m1.valid)) first_v = cyc;
         if (sel == 0 ? done : done1) break;
         if (toggle) m.ready = ~m.ready;
      end
      check("dump_done", 32'(sel == 0 ? done : done1), 32'd1);
   endtask

   task automatic check_dump(input string tag, input int sel, input int nwords,
                             input logic [31:0] cnt, input logic [1:0] cause, input logic we,
                             input logic [11:0] addr, input logic [11:0] pcv);
      logic [31:0] ws[$];
      bit          ls[$];
      if (sel == 0) begin ws = q0; ls = l0; end
      else          begin ws = q1; ls = l1; end
      check({tag, "_len"}, 32'(ws.size()), 32'(nwords));
      for (int k = 0; k < nwords && k < ws.size(); k++) begin
         check($sformatf("%s_w%0d", tag, k), ws[k], exp_word(k, cnt, cause, we, addr, pcv));
         check($sformatf("%s_last%0d", tag, k), 32'(ls[k]), 32'(k == nwords - 1));
      end
   endtask

   initial begin
      int cyc, fv;
      do_reset();
      check("rst_halt", 32'(halt), 32'd0);
      check("rst_valid", 32'(m.valid), 32'd0);
      check("rst_last", 32'(m.last), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_data", m.data, 32'd0);
      check("rst_raddr", 32'(raddr), 32'd0);

      // Trap at cycle 40, full 19-word dump with ready held high.
      fire(40, 1'b1, 1'b0, 1'b1, 12'h123, 12'h05A, 0);
      run_dump(0, 1'b0, cyc, fv);
      check("first_valid", 32'(fv), 32'd2);
      check("dump_cycles", 32'(cyc), 32'd55);
      check_dump("t1", 0, 19, 32'd40, 2'b01, 1'b1, 12'h123, 12'h05A);
      trap = 1'b1; dump_req = 1'b1;
      repeat (4) @(posedge clk);
      #1 trap = 1'b0; dump_req = 1'b0;
      check("done_sticky", 32'(done), 32'd1);
      check("done_valid", 32'(m.valid), 32'd0);
      check("done_words", 32'(q0.size()), 32'd19);

      // Trap and request together: trap wins; ready toggles every cycle.
      do_reset();
      fire(10, 1'b1, 1'b1, 1'b0, 12'hABC, 12'hFFF, 0);
      run_dump(0, 1'b1, cyc, fv);
      check_dump("t2", 0, 19, 32'd10, 2'b01, 1'b0, 12'hABC, 12'hFFF);

      // Reset while register word 5 (index 8) is on offer, then a fresh dump.
      do_reset();
      fire(5, 1'b0, 1'b1, 1'b1, 12'h001, 12'h200, 0);
      cyc = 0;
      while (cyc < 200 && !(q0.size() == 8 && m.valid)) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check("t3_reached", 32'(q0.size() == 8 && m.valid), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("mid_halt", 32'(halt), 32'd0);
      check("mid_valid", 32'(m.valid), 32'd0);
      check("mid_last", 32'(m.last), 32'd0);
      check("mid_done", 32'(done), 32'd0);
      check("mid_data", m.data, 32'd0);
      check("mid_raddr", 32'(raddr), 32'd0);
      rst = 1'b0;
      q0.delete(); l0.delete();
      fire(3, 1'b1, 1'b0, 1'b0, 12'h777, 12'h0AB, 0);
      run_dump(0, 1'b0, cyc, fv);
      check_dump("t3", 0, 19, 32'd3, 2'b01, 1'b0, 12'h777, 12'h0AB);

      // One-register instance, request in the very first RUN cycle.
      do_reset();
      fire(0, 1'b0, 1'b1, 1'b0, 12'h055, 12'h0C3, 1);
      run_dump(1, 1'b0, cyc, fv);
      check_dump("t4", 1, 4, 32'd0, 2'b11, 1'b0, 12'h055, 12'h0C3);

`ifdef XDBG_TIMEOUT_EN
      do_reset();
      run_dump(0, 1'b0, cyc, fv);
      check_dump("tmo", 0, 19, 32'd99, 2'b10, 1'b0, 12'h000, 12'h000);
`else
      do_reset();
      repeat (150) @(posedge clk);
      #1;
      check("no_tmo_halt", 32'(halt), 32'd0);
      check("no_tmo_valid", 32'(m.valid), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
